mem_arbiter: RTL and testbench

Shares the single-port byte-addressed RAM between the instruction-fetch port and the load/store data port of the core. It accepts at most one request per cycle via valid/ready handshakes and translates data requests into RAM read/write control codes. It rejects misaligned and out-of-range accesses without touching memory. Each port returns its response through a one-entry registered response slot with its own valid/ready handshake.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_rsp_slot.sv | 30 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and RAM control encodings for the core's memory arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_LW   = 3'b001;
    localparam logic [2:0] RD_LHU  = 3'b010;
    localparam logic [2:0] RD_LH   = 3'b011;
    localparam logic [2:0] RD_LBU  = 3'b100;
    localparam logic [2:0] RD_LB   = 3'b101;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_W    = 2'b11;
    localparam logic [1:0] WR_H    = 2'b01;
    localparam logic [1:0] WR_B    = 2'b10;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } mem_rsp_t;

    // The unused size code 11 is reported as misaligned so it never reaches the RAM.
    function automatic logic mem_misaligned(input logic [31:0] addr, input logic [1:0] size);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return addr[0];
            MEM_WORD: return addr[1:0] != 2'b00;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_rsp_slot.sv
// One-entry registered response holder with valid/ready; one instance per port.
import mem_pkg::*;

module mem_rsp_slot (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  mem_rsp_t ld,
    input  logic     rsp_ready,
    output logic     rsp_valid,
    output mem_rsp_t rsp,
    output logic     free
);

    // A slot being drained this cycle can accept a new response at the same edge.
    assign free = !rsp_valid || rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp       <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp       <= ld;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port byte RAM between instruction fetch and load/store,
// with a bounded data streak so fetch cannot starve.
import mem_pkg::*;

module mem_arbiter #(
    parameter int unsigned SIZE            = 4 << 20,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_we,
    input  logic [1:0]  d_req_size,
    input  logic        d_req_unsigned,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_rdata,
    output logic        d_rsp_err,
    output logic [31:0] ram_word_addr,
    output logic [31:0] ram_data_in,
    output logic [1:0]  ram_write_ctrl,
    output logic [2:0]  ram_read_ctrl,
    input  logic [31:0] ram_out
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [32:0]   SIZE_X     = 33'(SIZE);

    logic          if_free, d_free, if_elig, d_elig, if_win, d_win;
    logic [SW-1:0] streak;
    logic [31:0]   sel_addr;
    logic [1:0]    sel_size;
    logic          sel_we, sel_uns, sel_err, go;
    logic [32:0]   nbytes;
    mem_rsp_t      ld, if_rsp, d_rsp;

    assign if_elig = if_req_valid && if_free;
    assign d_elig  = d_req_valid && d_free;
    assign d_win   = rst_n && d_elig && !(if_elig && streak == STREAK_MAX);
    assign if_win  = rst_n && if_elig && !d_win;

    assign d_req_ready  = d_win;
    assign if_req_ready = if_win;

    // Fetch is always a word read, so the shared path only needs data fields when data wins.
    assign sel_addr = d_win ? d_req_addr : if_req_addr;
    assign sel_size = d_win ? d_req_size : MEM_WORD;
    assign sel_we   = d_win && d_req_we;
    assign sel_uns  = d_win && d_req_unsigned;

    always_comb begin
        case (sel_size)
            MEM_BYTE: nbytes = 33'd1;
            MEM_HALF: nbytes = 33'd2;
            default:  nbytes = 33'd4;
        endcase
    end

    assign sel_err = mem_misaligned(sel_addr, sel_size) || ({1'b0, sel_addr} + nbytes > SIZE_X);
    assign go      = (d_win || if_win) && !sel_err;

    always_comb begin
        ram_word_addr  = '0;
        ram_data_in    = '0;
        ram_write_ctrl = WR_NONE;
        ram_read_ctrl  = RD_NONE;
        if (go) begin
            ram_word_addr = sel_addr;
            if (sel_we) begin
                ram_data_in = d_req_wdata;
                case (sel_size)
                    MEM_BYTE: ram_write_ctrl = WR_B;
                    MEM_HALF: ram_write_ctrl = WR_H;
                    default:  ram_write_ctrl = WR_W;
                endcase
            end else begin
                case (sel_size)
                    MEM_BYTE: ram_read_ctrl = sel_uns ? RD_LBU : RD_LB;
                    MEM_HALF: ram_read_ctrl = sel_uns ? RD_LHU : RD_LH;
                    default:  ram_read_ctrl = RD_LW;
                endcase
            end
        end
    end

    assign ld.err  = sel_err;
    assign ld.data = (go && !sel_we) ? ram_out : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            streak <= '0;
        else if (!if_elig || if_win)
            streak <= '0;
        else if (d_win && streak != STREAK_MAX)
            streak <= streak + 1'b1;
    end

    mem_rsp_slot u_if_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (if_win),
        .ld        (ld),
        .rsp_ready (if_rsp_ready),
        .rsp_valid (if_rsp_valid),
        .rsp       (if_rsp),
        .free      (if_free)
    );

    mem_rsp_slot u_d_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (d_win),
        .ld        (ld),
        .rsp_ready (d_rsp_ready),
        .rsp_valid (d_rsp_valid),
        .rsp       (d_rsp),
        .free      (d_free)
    );

    assign if_rsp_data = if_rsp.data;
    assign if_rsp_err  = if_rsp.err;
    assign d_rsp_rdata = d_rsp.data;
    assign d_rsp_err   = d_rsp.err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-array RAM fixture plus a separate
// byte-level reference memory and rule-based arbitration model.
module tb_mem_arbiter;
    localparam int unsigned SIZE = 4 << 20;
    localparam int MAXS = 4;

    logic        clk, rst_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_req_unsigned;
    logic        d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [1:0]  d_req_size;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
    logic [31:0] ram_word_addr, ram_data_in, ram_out;
    logic [1:0]  ram_write_ctrl;
    logic [2:0]  ram_read_ctrl;

    int n_chk = 0;
    int n_fail = 0;

    mem_arbiter #(.SIZE(SIZE), .MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
        .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_size(d_req_size), .d_req_unsigned(d_req_unsigned),
        .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
        .d_rsp_err(d_rsp_err),
        .ram_word_addr(ram_word_addr), .ram_data_in(ram_data_in),
        .ram_write_ctrl(ram_write_ctrl), .ram_read_ctrl(ram_read_ctrl), .ram_out(ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM fixture: writes at the edge, combinational extended reads.
    bit [7:0] ram [SIZE];

    always @(posedge clk) begin
        case (ram_write_ctrl)
            2'b11: for (int k = 0; k < 4; k++) ram[(ram_word_addr + k) % SIZE] <= ram_data_in[8*k +: 8];
            2'b01: for (int k = 0; k < 2; k++) ram[(ram_word_addr + k) % SIZE] <= ram_data_in[8*k +: 8];
            2'b10: ram[ram_word_addr % SIZE] <= ram_data_in[7:0];
            default: ;
        endcase
    end

    function automatic logic [31:0] ram_rd(input logic [2:0] rc, input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ram[a % SIZE];
        b1 = ram[(a + 1) % SIZE];
        b2 = ram[(a + 2) % SIZE];
        b3 = ram[(a + 3) % SIZE];
        case (rc)
            3'b001: return {b3, b2, b1, b0};
            3'b010: return {16'h0, b1, b0};
            3'b011: return {{16{b1[7]}}, b1, b0};
            3'b100: return {24'h0, b0};
            3'b101: return {{24{b0[7]}}, b0};
            default: return 32'h0;
        endcase
    endfunction

    assign ram_out = ram_rd(ram_read_ctrl, ram_word_addr);

    // Reference model, driven only by what the bench intends to happen.
    byte unsigned ref_mem [int unsigned];

    function automatic bit ref_err(input logic [31:0] a, input logic [1:0] sz);
        longint n;
        if (sz == 2'b11) return 1'b1;
        n = longint'(1) << sz;
        if (longint'(a) > longint'(SIZE) - n) return 1'b1;
        return (longint'(a) % n) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        longint v, n;
        n = longint'(1) << sz;
        v = 0;
        for (int i = 0; i < n; i++)
            if (ref_mem.exists(a + i)) v = v + (longint'(ref_mem[a + i]) << (8 * i));
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_mem[a + i] = 8'(wd >> (8 * i));
    endtask

    function automatic logic [2:0] exp_rc(input logic [1:0] sz, input logic uns);
        if (sz == 2'b10) return 3'b001;
        if (sz == 2'b01) return uns ? 3'b010 : 3'b011;
        return uns ? 3'b100 : 3'b101;
    endfunction

    function automatic logic [1:0] exp_wc(input logic [1:0] sz);
        if (sz == 2'b10) return 2'b11;
        if (sz == 2'b01) return 2'b01;
        return 2'b10;
    endfunction

    // Drive one data request, wait (bounded) for acceptance, capture accept-cycle RAM controls and the T+1 response.
    task automatic data_txn(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] wd, output logic ok, output logic [1:0] wc,
                            output logic [2:0] rc, output logic [31:0] rsp, output logic err, output logic rv);
        int cnt;
        @(negedge clk);
        d_req_addr = a; d_req_we = we; d_req_size = sz; d_req_unsigned = uns; d_req_wdata = wd;
        d_req_valid = 1'b1;
        #1;
        cnt = 0;
        while (!d_req_ready && cnt < 20) begin @(negedge clk); #1; cnt++; end
        ok = d_req_ready; wc = ram_write_ctrl; rc = ram_read_ctrl;
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        rv = d_rsp_valid; rsp = d_rsp_rdata; err = d_rsp_err;
    endtask

    task automatic fetch_txn(input logic [31:0] a, output logic ok, output logic [2:0] rc,
                             output logic [31:0] rsp, output logic err, output logic rv);
        int cnt;
        @(negedge clk);
        if_req_addr = a; if_req_valid = 1'b1;
        #1;
        cnt = 0;
        while (!if_req_ready && cnt < 20) begin @(negedge clk); #1; cnt++; end
        ok = if_req_ready; rc = ram_read_ctrl;
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        rv = if_rsp_valid; rsp = if_rsp_data; err = if_rsp_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 32'h0; if_rsp_ready = 1'b1;
        d_req_valid = 1'b1; d_req_addr = 32'h100; d_req_we = 1'b1; d_req_size = 2'b10;
        d_req_unsigned = 1'b0; d_req_wdata = 32'h5555_AAAA; d_rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_chk++; if ({if_req_ready, d_req_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {if_req_ready, d_req_ready}); end
        n_chk++; if ({ram_write_ctrl, ram_read_ctrl, ram_word_addr, ram_data_in} !== '0) begin n_fail++; $display("FAIL reset_ram_ctrl: got wc=%b rc=%b a=%h d=%h want 0", ram_write_ctrl, ram_read_ctrl, ram_word_addr, ram_data_in); end
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if ({if_rsp_valid, d_rsp_valid, if_rsp_err, d_rsp_err, if_rsp_data, d_rsp_rdata} !== '0) begin n_fail++; $display("FAIL reset_rsp: got ifv=%b dv=%b ife=%b de=%b ifd=%h dd=%h want 0", if_rsp_valid, d_rsp_valid, if_rsp_err, d_rsp_err, if_rsp_data, d_rsp_rdata); end
        @(negedge clk);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        logic ok, err, rv; logic [1:0] wc; logic [2:0] rc; logic [31:0] rsp;
        @(negedge clk);
        d_req_addr = 32'h100; d_req_we = 1'b1; d_req_size = 2'b10; d_req_wdata = 32'hDEAD_BEEF; d_req_valid = 1'b1;
        #1;
        n_chk++; if ({d_req_ready, ram_write_ctrl, ram_word_addr, ram_data_in} !== {1'b1, 2'b11, 32'h100, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL store_drive: got rdy=%b wc=%b a=%h d=%h want 1 11 100 deadbeef", d_req_ready, ram_write_ctrl, ram_word_addr, ram_data_in); end
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        ref_store(32'h100, 2'b10, 32'hDEAD_BEEF);
        n_chk++; if ({d_rsp_valid, d_rsp_err, d_rsp_rdata} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL store_rsp: got v=%b e=%b d=%h want 1 0 0", d_rsp_valid, d_rsp_err, d_rsp_rdata); end
        data_txn(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, ok, wc, rc, rsp, err, rv);
        n_chk++; if ({ok, rv, err, rc, rsp} !== {3'b110, 3'b001, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL load_word: got ok=%b v=%b e=%b rc=%b d=%h want 1 1 0 001 deadbeef", ok, rv, err, rc, rsp); end
    endtask

    task automatic test_extension();
        logic ok, err, rv; logic [1:0] wc; logic [2:0] rc; logic [31:0] rsp;
        data_txn(32'h200, 1'b1, 2'b00, 1'b0, 32'h0000_0080, ok, wc, rc, rsp, err, rv);
        ref_store(32'h200, 2'b00, 32'h80);
        n_chk++; if ({ok, wc, err} !== {1'b1, 2'b10, 1'b0}) begin n_fail++; $display("FAIL store_byte: got ok=%b wc=%b e=%b want 1 10 0", ok, wc, err); end
        data_txn(32'h200, 1'b0, 2'b00, 1'b0, 32'h0, ok, wc, rc, rsp, err, rv);
        n_chk++; if ({rc, rsp} !== {3'b101, 32'hFFFF_FF80}) begin n_fail++; $display("FAIL lb: got rc=%b d=%h want 101 ffffff80", rc, rsp); end
        data_txn(32'h200, 1'b0, 2'b00, 1'b1, 32'h0, ok, wc, rc, rsp, err, rv);
        n_chk++; if ({rc, rsp} !== {3'b100, 32'h0000_0080}) begin n_fail++; $display("FAIL lbu: got rc=%b d=%h want 100 00000080", rc, rsp); end
        data_txn(32'h202, 1'b1, 2'b01, 1'b0, 32'h0000_8001, ok, wc, rc, rsp, err, rv);
        ref_store(32'h202, 2'b01, 32'h8001);
        n_chk++; if ({ok, wc} !== {1'b1, 2'b01}) begin n_fail++; $display("FAIL store_half: got ok=%b wc=%b want 1 01", ok, wc); end
        data_txn(32'h202, 1'b0, 2'b01, 1'b0, 32'h0, ok, wc, rc, rsp, err, rv);
        n_chk++; if ({rc, rsp} !== {3'b011, 32'hFFFF_8001}) begin n_fail++; $display("FAIL lh: got rc=%b d=%h want 011 ffff8001", rc, rsp); end
    endtask

    task automatic test_errors();
        logic ok, err, rv; logic [1:0] wc; logic [2:0] rc; logic [31:0] rsp;
        data_txn(32'h102, 1'b0, 2'b10, 1'b0, 32'h0, ok, wc, rc, rsp, err, rv);
        n_chk++; if ({ok, rv, err, rc, rsp} !== {3'b111, 3'b000, 32'h0}) begin n_fail++; $display("FAIL misaligned_lw: got ok=%b v=%b e=%b rc=%b d=%h want 1 1 1 000 0", ok, rv, err, rc, rsp); end
        fetch_txn(SIZE - 2, ok, rc, rsp, err, rv);
        n_chk++; if ({ok, rv, err, rc, rsp} !== {3'b111, 3'b000, 32'h0}) begin n_fail++; $display("FAIL fetch_end: got ok=%b v=%b e=%b rc=%b d=%h want 1 1 1 000 0", ok, rv, err, rc, rsp); end
        data_txn(32'h100, 1'b1, 2'b11, 1'b0, 32'h1234_5678, ok, wc, rc, rsp, err, rv);
        n_chk++; if ({ok, err, wc} !== {2'b11, 2'b00}) begin n_fail++; $display("FAIL size11_store: got ok=%b e=%b wc=%b want 1 1 00", ok, err, wc); end
        data_txn(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, ok, wc, rc, rsp, err, rv);
        n_chk++; if (rsp !== ref_load(32'h100, 2'b10, 1'b0)) begin n_fail++; $display("FAIL size11_unchanged: got %h want %h", rsp, ref_load(32'h100, 2'b10, 1'b0)); end
        // Highest legal addresses for each size, and one past the end.
        data_txn(SIZE - 1, 1'b1, 2'b00, 1'b0, 32'h0000_00A5, ok, wc, rc, rsp, err, rv);
        ref_store(SIZE - 1, 2'b00, 32'hA5);
        n_chk++; if ({err, wc} !== {1'b0, 2'b10}) begin n_fail++; $display("FAIL last_byte_store: got e=%b wc=%b want 0 10", err, wc); end
        fetch_txn(SIZE - 4, ok, rc, rsp, err, rv);
        n_chk++; if ({err, rsp} !== {1'b0, ref_load(SIZE - 4, 2'b10, 1'b0)}) begin n_fail++; $display("FAIL fetch_last_word: got e=%b d=%h want 0 %h", err, rsp, ref_load(SIZE - 4, 2'b10, 1'b0)); end
        data_txn(SIZE, 1'b0, 2'b00, 1'b1, 32'h0, ok, wc, rc, rsp, err, rv);
        n_chk++; if ({err, rc} !== {1'b1, 3'b000}) begin n_fail++; $display("FAIL past_end_byte: got e=%b rc=%b want 1 000", err, rc); end
    endtask

    task automatic test_fairness();
        int streak_m;
        logic exp_d;
        streak_m = 0;
        @(negedge clk);
        d_req_addr = 32'h100; d_req_we = 1'b0; d_req_size = 2'b10; d_req_unsigned = 1'b0;
        if_req_addr = 32'h200;
        d_req_valid = 1'b1; if_req_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            exp_d = (streak_m != MAXS);
            n_chk++; if ({d_req_ready, if_req_ready} !== {exp_d, !exp_d}) begin n_fail++; $display("FAIL fairness_cycle%0d: got d=%b f=%b want d=%b f=%b", i, d_req_ready, if_req_ready, exp_d, !exp_d); end
            streak_m = exp_d ? streak_m + 1 : 0;
            @(negedge clk);
        end
        d_req_valid = 1'b0; if_req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] first;
        first = ref_load(32'h100, 2'b10, 1'b0);
        @(negedge clk);
        d_rsp_ready = 1'b0;
        d_req_addr = 32'h100; d_req_we = 1'b0; d_req_size = 2'b10; d_req_unsigned = 1'b0; d_req_valid = 1'b1;
        #1;
        n_chk++; if (d_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_accept: got %b want 1", d_req_ready); end
        @(negedge clk);
        d_req_addr = 32'h200; d_req_size = 2'b00; d_req_unsigned = 1'b1;
        if_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_req_addr = 32'h100 + 32'(4 * i);
            #1;
            n_chk++; if ({d_req_ready, if_req_ready, d_rsp_valid, d_rsp_rdata} !== {3'b011, first}) begin n_fail++; $display("FAIL bp_hold%0d: got dr=%b fr=%b dv=%b dd=%h want 0 1 1 %h", i, d_req_ready, if_req_ready, d_rsp_valid, d_rsp_rdata, first); end
            @(posedge clk); #1;
            n_chk++; if ({if_rsp_valid, if_rsp_data} !== {1'b1, ref_load(32'h100 + 32'(4 * i), 2'b10, 1'b0)}) begin n_fail++; $display("FAIL bp_fetch%0d: got v=%b d=%h want 1 %h", i, if_rsp_valid, if_rsp_data, ref_load(32'h100 + 32'(4 * i), 2'b10, 1'b0)); end
            @(negedge clk);
        end
        d_rsp_ready = 1'b1;
        #1;
        n_chk++; if ({d_req_ready, if_req_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_release: got d=%b f=%b want 1 0", d_req_ready, if_req_ready); end
        @(posedge clk); #1;
        n_chk++; if ({d_rsp_valid, d_rsp_rdata} !== {1'b1, ref_load(32'h200, 2'b00, 1'b1)}) begin n_fail++; $display("FAIL bp_second_rsp: got v=%b d=%h want 1 %h", d_rsp_valid, d_rsp_rdata, ref_load(32'h200, 2'b00, 1'b1)); end
        @(negedge clk);
        d_req_valid = 1'b0; if_req_valid = 1'b0;
    endtask

    task automatic test_random();
        logic ok, err, rv, we, uns, e_err; logic [1:0] wc, sz; logic [2:0] rc; logic [31:0] rsp, a, wd, e_d;
        for (int i = 0; i < 60; i++) begin
            a = 32'h1000 + $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) a = SIZE - $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) begin
                e_err = ref_err(a, 2'b10);
                e_d = e_err ? 32'h0 : ref_load(a, 2'b10, 1'b0);
                fetch_txn(a, ok, rc, rsp, err, rv);
                n_chk++; if ({ok, rv, err, rsp} !== {2'b11, e_err, e_d}) begin n_fail++; $display("FAIL rnd_fetch%0d a=%h: got ok=%b v=%b e=%b d=%h want 1 1 %b %h", i, a, ok, rv, err, rsp, e_err, e_d); end
            end else begin
                sz = 2'($urandom_range(0, 3)); we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
                wd = $urandom;
                e_err = ref_err(a, sz);
                e_d = (e_err || we) ? 32'h0 : ref_load(a, sz, uns);
                data_txn(a, we, sz, uns, wd, ok, wc, rc, rsp, err, rv);
                if (we && !e_err) ref_store(a, sz, wd);
                n_chk++;
                if ({ok, rv, err, rsp, wc, rc} !== {2'b11, e_err, e_d, (we && !e_err) ? exp_wc(sz) : 2'b00, (!we && !e_err) ? exp_rc(sz, uns) : 3'b000}) begin
                    n_fail++; $display("FAIL rnd_data%0d a=%h we=%b sz=%b u=%b: got ok=%b v=%b e=%b d=%h wc=%b rc=%b want e=%b d=%h", i, a, we, sz, uns, ok, rv, err, rsp, wc, rc, e_err, e_d);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic ok, err, rv; logic [1:0] wc; logic [2:0] rc; logic [31:0] rsp;
        @(negedge clk);
        if_rsp_ready = 1'b0; d_rsp_ready = 1'b0;
        d_req_addr = 32'h100; d_req_we = 1'b0; d_req_size = 2'b10; d_req_valid = 1'b1;
        if_req_addr = 32'h104; if_req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        n_chk++; if ({if_rsp_valid, d_rsp_valid} !== 2'b11) begin n_fail++; $display("FAIL ar_both_full: got f=%b d=%b want 1 1", if_rsp_valid, d_rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({if_rsp_valid, d_rsp_valid, if_req_ready, d_req_ready, d_rsp_rdata, if_rsp_data} !== '0) begin n_fail++; $display("FAIL ar_immediate: got fv=%b dv=%b fr=%b dr=%b dd=%h fd=%h want 0", if_rsp_valid, d_rsp_valid, if_req_ready, d_req_ready, d_rsp_rdata, if_rsp_data); end
        @(negedge clk);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        if_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        rst_n = 1'b1;
        data_txn(32'h200, 1'b0, 2'b00, 1'b1, 32'h0, ok, wc, rc, rsp, err, rv);
        n_chk++; if ({ok, rv, err, rsp, if_rsp_valid} !== {3'b110, ref_load(32'h200, 2'b00, 1'b1), 1'b0}) begin n_fail++; $display("FAIL ar_after: got ok=%b v=%b e=%b d=%h fv=%b want 1 1 0 %h 0", ok, rv, err, rsp, if_rsp_valid, ref_load(32'h200, 2'b00, 1'b1)); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extension();
        test_errors();
        test_fairness();
        test_backpressure();
        test_random();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
